mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer that shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage RISC-V pipeline. It grants one transaction at a time and holds the memory request until the memory acknowledges, errors or times out. It returns data and a one-cycle done pulse to the owner and produces the fetch/data stall levels that feed `v_mem_stall` and the fetch stall. Data requests have priority, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- `MAX_WAIT`, 3: consecutive data grants allowed while fetch is pending before fetch is forced.
- `TIMEOUT`, 255: cycles in BUSY without `M_ACK`/`M_ERR` before abort with fault (8-bit counter).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high.
- `IF_REQ` in 1: fetch read request (level, held until `IF_DONE`).
- `IF_ADDR` in 64: fetch address.
- `IF_RDATA` out 32: instruction word.
- `IF_DONE` out 1: one-cycle completion pulse.
- `IF_FAULT` out 1: valid with `IF_DONE`; access fault.
- `IF_STALL` out 1: `IF_REQ & ~IF_DONE`.
- `D_REQ` in 1: data request (level, held until `D_DONE`).
- `D_WE` in 1: 1 = store.
- `D_SIZE` in 2: 0 = B, 1 = H, 2 = W, 3 = D.
- `D_ADDR` in 64: data address.
- `D_WDATA` in 64: store data.
- `D_RDATA` out 64: raw aligned doubleword from memory.
- `D_DONE` out 1: one-cycle completion pulse.
- `D_FAULT` out 1: valid with `D_DONE`.
- `D_STALL` out 1: `D_REQ & ~D_DONE`.
- `M_REQ` out 1: memory request, held until ack, error or abort.
- `M_WE` out 1: memory write enable.
- `M_SIZE` out 2: memory access size.
- `M_ADDR` out 64: memory address.
- `M_WDATA` out 64: memory write data.
- `M_RDATA` in 64: memory read data, valid with `M_ACK`.
- `M_ACK` in 1: transaction complete.
- `M_ERR` in 1: bus error; terminates the transaction like an ack.
- `OWNER_D` out 1: current or last grant was data; debug only.

## Operation
- FSM states: IDLE, BUSY, RESP. Arbitration happens only in IDLE.
- IDLE, grant rule at a clock edge:
  - If `D_REQ` and (`!IF_REQ` or `starve < MAX_WAIT`), grant data.
  - Otherwise, if `IF_REQ`, grant fetch.
  - Otherwise, stay in IDLE.
- On a grant, latch the owner, address, WE, size and wdata, then go to BUSY.
  - Fetch grants force `M_WE=0` and `M_SIZE=2`.
  - `M_ADDR` carries the full address.
- Starvation counter (2-bit, saturating at `MAX_WAIT`):
  - Increments on a data grant while `IF_REQ` is high.
  - Clears on a fetch grant.
  - Unchanged otherwise.
- BUSY:
  - `M_REQ=1` with latched fields.
  - The timeout counter increments each cycle.
  - On `M_ACK` or `M_ERR` sampled high: latch read data and fault (`fault=M_ERR`), go to RESP.
  - If both `M_ACK` and `M_ERR` are high, the error wins.
  - If the timeout counter reaches `TIMEOUT`: go to RESP with fault=1 and read data 0.
- RESP:
  - The owner's DONE=1 for exactly one cycle, with FAULT and RDATA valid; then go to IDLE.
  - On a fetch fault, `IF_RDATA` is 0.
- `IF_RDATA` = `rdata[31:0]` if latched `addr[2]`=0, else `rdata[63:32]`.
- `D_RDATA` holds the full 64-bit word. The memory stage does extraction, sign extension and alignment checks; this block does not check alignment.
- RDATA outputs hold their last value until the next RESP.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; starvation and timeout counters 0.
  - `OWNER_D=0`.
  - `RESET` asserted mid-transaction drops `M_REQ` immediately (async). No DONE is generated, and the transaction is lost.
- Request sampled at edge 0 → `M_REQ` high from edge 0.
- `M_ACK` sampled at edge k → `M_REQ` low after edge k, DONE high during cycle k..k+1, IDLE at edge k+1.
- Minimum service time: request to DONE is 2 cycles (ack at edge 1), and the port is occupied for 3 cycles per transaction.
- No back-to-back grant out of RESP. A requester must drop REQ in the cycle after it sees DONE.
  - A REQ still high at the IDLE edge is treated as a new request.
- `M_REQ` and latched fields must not change during BUSY.
- `M_ACK` arriving in IDLE or RESP is ignored.
- Simultaneous new requests are resolved only by the grant rule.
- Requests that arrive during BUSY or RESP wait. The waiting requester's STALL stays high.

## Test plan
- Single fetch: `IF_REQ` with `IF_ADDR=0x1004`, memory returns `M_RDATA=0xAAAA_BBBB_CCCC_DDDD` with ack at edge 1 → `IF_DONE` pulse in cycle 1, `IF_RDATA=0xAAAABBBB`, `IF_FAULT=0`, `M_WE=0`, `M_SIZE=2`.
- Data store: `D_REQ`, `D_WE=1`, `D_SIZE=1`, `D_ADDR=0x2002`, `D_WDATA=0x1234`, ack delayed by 5 cycles → `M_*` fields stable for 5 cycles, `D_STALL` high until `D_DONE`, then one `D_DONE` pulse.
- Contention and starvation: `D_REQ` and `IF_REQ` held continuously, with the data requester re-requesting every time → grant order D, D, D, IF, D, D, D, IF.
- Error: `M_ACK=1` and `M_ERR=1` in the same cycle on a data load → `D_DONE=1`, `D_FAULT=1`.
- Timeout: fetch with no ack → `IF_DONE` and `IF_FAULT=1` exactly `TIMEOUT` cycles after the grant edge, `IF_RDATA=0`, `M_REQ` low afterwards.
- Reset mid-BUSY: assert `RESET` between edges → `M_REQ`, `IF_DONE` and `D_DONE` go 0 immediately. After release, a new `D_REQ` is served normally with the starvation counter at 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between the fetch stage (instruction
// reads) and the memory stage (data loads/stores). One transaction is in
// flight at a time. Data requests win arbitration, but a small starvation
// counter forces a fetch grant after MAX_WAIT consecutive data grants taken
// while fetch was waiting.
//
// The sequencer has three states:
//   IDLE - arbitrate; a grant latches the request fields and moves to BUSY
//   BUSY - M_REQ held with the latched fields until M_ACK, M_ERR or timeout
//   RESP - one-cycle DONE pulse to the owner with FAULT/RDATA valid
//
// Ports
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   IF_REQ/IF_ADDR        fetch read request, level held until IF_DONE
//   IF_RDATA/IF_DONE/IF_FAULT/IF_STALL
//                         32-bit instruction word, completion pulse, fault,
//                         stall level (IF_REQ & ~IF_DONE)
//   D_REQ/D_WE/D_SIZE/D_ADDR/D_WDATA
//                         data request, held until D_DONE
//   D_RDATA/D_DONE/D_FAULT/D_STALL
//                         raw 64-bit word, completion pulse, fault, stall level
//   M_REQ/M_WE/M_SIZE/M_ADDR/M_WDATA
//                         memory request and its latched fields
//   M_RDATA/M_ACK/M_ERR   memory read data, completion, bus error
//   OWNER_D               current or last grant went to data (debug)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MAX_WAIT = 3,    // data grants allowed while fetch waits
  parameter int TIMEOUT  = 255   // BUSY cycles before abort with fault
) (
  input  logic        CLK,
  input  logic        RESET,
  // fetch requester
  input  logic        IF_REQ,
  input  logic [63:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_DONE,
  output logic        IF_FAULT,
  output logic        IF_STALL,
  // data requester
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [1:0]  D_SIZE,
  input  logic [63:0] D_ADDR,
  input  logic [63:0] D_WDATA,
  output logic [63:0] D_RDATA,
  output logic        D_DONE,
  output logic        D_FAULT,
  output logic        D_STALL,
  // memory port
  output logic        M_REQ,
  output logic        M_WE,
  output logic [1:0]  M_SIZE,
  output logic [63:0] M_ADDR,
  output logic [63:0] M_WDATA,
  input  logic [63:0] M_RDATA,
  input  logic        M_ACK,
  input  logic        M_ERR,
  // debug
  output logic        OWNER_D
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] MAX_WAIT_C = 2'(MAX_WAIT);
  // The abort fires on the edge where the counter would reach TIMEOUT, so the
  // fault response starts exactly TIMEOUT cycles after the grant edge.
  localparam logic [7:0] TMO_LAST_C = 8'(TIMEOUT - 1);
  localparam logic [1:0] SIZE_WORD  = 2'd2;

  state_e      state_q,    state_d;
  logic        owner_q,    owner_d;     // 1 = data owns the port
  logic [63:0] addr_q,     addr_d;
  logic        we_q,       we_d;
  logic [1:0]  size_q,     size_d;
  logic [63:0] wdata_q,    wdata_d;
  logic [1:0]  starve_q,   starve_d;
  logic [7:0]  tmo_q,      tmo_d;
  logic        fault_q,    fault_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [63:0] d_rdata_q,  d_rdata_d;

  logic grant_data;
  logic grant_fetch;

  // Data wins unless fetch is waiting and has already been passed over
  // MAX_WAIT times in a row.
  assign grant_data  = D_REQ && (!IF_REQ || (starve_q < MAX_WAIT_C));
  assign grant_fetch = IF_REQ && !grant_data;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    fault_d    = fault_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (grant_data) begin
          state_d = ST_BUSY;
          owner_d = 1'b1;
          addr_d  = D_ADDR;
          we_d    = D_WE;
          size_d  = D_SIZE;
          wdata_d = D_WDATA;
          // Only grants that bypass a waiting fetch count toward starvation.
          if (IF_REQ && (starve_q < MAX_WAIT_C)) begin
            starve_d = starve_q + 2'd1;
          end
        end else if (grant_fetch) begin
          state_d  = ST_BUSY;
          owner_d  = 1'b0;
          addr_d   = IF_ADDR;
          we_d     = 1'b0;
          size_d   = SIZE_WORD;
          wdata_d  = '0;
          starve_d = '0;
        end
      end

      ST_BUSY: begin
        tmo_d = tmo_q + 8'd1;
        if (M_ACK || M_ERR) begin
          state_d = ST_RESP;
          fault_d = M_ERR;               // error wins over a coincident ack
          if (owner_q) begin
            d_rdata_d = M_RDATA;
          end else if (M_ERR) begin
            if_rdata_d = '0;
          end else begin
            if_rdata_d = addr_q[2] ? M_RDATA[63:32] : M_RDATA[31:0];
          end
        end else if (tmo_q == TMO_LAST_C) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
          if (owner_q) begin
            d_rdata_d = '0;
          end else begin
            if_rdata_d = '0;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      tmo_q      <= '0;
      fault_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      fault_q    <= fault_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Outputs decode directly from registered state, so an asynchronous reset
  // drops M_REQ and any DONE pulse without waiting for a clock edge.
  assign M_REQ    = (state_q == ST_BUSY);
  assign M_WE     = we_q;
  assign M_SIZE   = size_q;
  assign M_ADDR   = addr_q;
  assign M_WDATA  = wdata_q;

  assign IF_DONE  = (state_q == ST_RESP) && !owner_q;
  assign D_DONE   = (state_q == ST_RESP) &&  owner_q;
  assign IF_FAULT = IF_DONE && fault_q;
  assign D_FAULT  = D_DONE  && fault_q;
  assign IF_RDATA = if_rdata_q;
  assign D_RDATA  = d_rdata_q;

  assign IF_STALL = IF_REQ && !IF_DONE;
  assign D_STALL  = D_REQ  && !D_DONE;

  assign OWNER_D  = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for mem_port_arbiter. Inputs are driven and outputs are
// sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RESET;
  logic        IF_REQ;
  logic [63:0] IF_ADDR;
  logic [31:0] IF_RDATA;
  logic        IF_DONE;
  logic        IF_FAULT;
  logic        IF_STALL;
  logic        D_REQ;
  logic        D_WE;
  logic [1:0]  D_SIZE;
  logic [63:0] D_ADDR;
  logic [63:0] D_WDATA;
  logic [63:0] D_RDATA;
  logic        D_DONE;
  logic        D_FAULT;
  logic        D_STALL;
  logic        M_REQ;
  logic        M_WE;
  logic [1:0]  M_SIZE;
  logic [63:0] M_ADDR;
  logic [63:0] M_WDATA;
  logic [63:0] M_RDATA;
  logic        M_ACK;
  logic        M_ERR;
  logic        OWNER_D;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_WAIT(3), .TIMEOUT(255)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IF_REQ   (IF_REQ),
    .IF_ADDR  (IF_ADDR),
    .IF_RDATA (IF_RDATA),
    .IF_DONE  (IF_DONE),
    .IF_FAULT (IF_FAULT),
    .IF_STALL (IF_STALL),
    .D_REQ    (D_REQ),
    .D_WE     (D_WE),
    .D_SIZE   (D_SIZE),
    .D_ADDR   (D_ADDR),
    .D_WDATA  (D_WDATA),
    .D_RDATA  (D_RDATA),
    .D_DONE   (D_DONE),
    .D_FAULT  (D_FAULT),
    .D_STALL  (D_STALL),
    .M_REQ    (M_REQ),
    .M_WE     (M_WE),
    .M_SIZE   (M_SIZE),
    .M_ADDR   (M_ADDR),
    .M_WDATA  (M_WDATA),
    .M_RDATA  (M_RDATA),
    .M_ACK    (M_ACK),
    .M_ERR    (M_ERR),
    .OWNER_D  (OWNER_D)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One complete transaction with both requesters held high: grant, ack on
  // the next edge, RESP, back to IDLE.
  task automatic contend_txn(input string tag, input logic exp_owner);
    step();
    check({tag, "_mreq"},  64'(M_REQ),   64'd1);
    check({tag, "_owner"}, 64'(OWNER_D), 64'(exp_owner));
    M_ACK = 1'b1;
    step();
    M_ACK = 1'b0;
    check({tag, "_done"},  {62'd0, D_DONE, IF_DONE}, exp_owner ? 64'd2 : 64'd1);
    step();
  endtask

  initial begin
    int n;
    RESET   = 1'b1;
    IF_REQ  = 1'b0;
    IF_ADDR = '0;
    D_REQ   = 1'b0;
    D_WE    = 1'b0;
    D_SIZE  = '0;
    D_ADDR  = '0;
    D_WDATA = '0;
    M_RDATA = '0;
    M_ACK   = 1'b0;
    M_ERR   = 1'b0;

    // ---------------- reset state ----------------
    step();
    check("rst_mreq",   64'(M_REQ),   64'd0);
    check("rst_done",   {62'd0, D_DONE, IF_DONE}, 64'd0);
    check("rst_owner",  64'(OWNER_D), 64'd0);
    check("rst_rdata",  D_RDATA | 64'(IF_RDATA), 64'd0);
    check("rst_fields", M_ADDR | M_WDATA | 64'(M_SIZE) | 64'(M_WE), 64'd0);
    step();
    RESET = 1'b0;
    step();
    check("idle_mreq", 64'(M_REQ), 64'd0);

    // ---------------- single fetch ----------------
    IF_REQ  = 1'b1;
    IF_ADDR = 64'h1004;
    #1;
    check("fetch_stall_pre", 64'(IF_STALL), 64'd1);
    step();                                   // grant edge 0
    check("fetch_mreq",  64'(M_REQ),  64'd1);
    check("fetch_mwe",   64'(M_WE),   64'd0);
    check("fetch_msize", 64'(M_SIZE), 64'd2);
    check("fetch_maddr", M_ADDR,      64'h1004);
    check("fetch_owner", 64'(OWNER_D), 64'd0);
    M_ACK   = 1'b1;
    M_RDATA = 64'hAAAA_BBBB_CCCC_DDDD;
    step();                                   // ack sampled at edge 1
    M_ACK = 1'b0;
    check("fetch_done",   64'(IF_DONE),  64'd1);
    check("fetch_rdata",  64'(IF_RDATA), 64'hAAAA_BBBB);
    check("fetch_fault",  64'(IF_FAULT), 64'd0);
    check("fetch_stall",  64'(IF_STALL), 64'd0);
    check("fetch_mreq_lo", 64'(M_REQ),   64'd0);
    IF_REQ = 1'b0;
    step();
    check("fetch_done_pulse", 64'(IF_DONE),  64'd0);
    check("fetch_rdata_hold", 64'(IF_RDATA), 64'hAAAA_BBBB);

    // ---------------- data store, ack after 5 cycles ----------------
    D_REQ   = 1'b1;
    D_WE    = 1'b1;
    D_SIZE  = 2'd1;
    D_ADDR  = 64'h2002;
    D_WDATA = 64'h1234;
    step();                                   // grant edge 0
    // Disturb the request inputs; the memory fields must stay latched.
    D_ADDR  = 64'hFFFF_0000;
    D_WDATA = 64'h5555;
    D_SIZE  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      check("store_mreq",   64'(M_REQ),   64'd1);
      check("store_fields", {M_ADDR[31:0], 16'h0, M_WDATA[15:0], 13'h0, M_WE, M_SIZE},
                            {32'h2002, 16'h0, 16'h1234, 13'h0, 1'b1, 2'd1});
      check("store_stall",  {62'd0, D_STALL, D_DONE}, 64'd2);
      if (i == 4) M_ACK = 1'b1;
      step();
    end
    M_ACK = 1'b0;                             // ack sampled at edge 5
    check("store_done",  64'(D_DONE),  64'd1);
    check("store_fault", 64'(D_FAULT), 64'd0);
    check("store_stall_lo", 64'(D_STALL), 64'd0);
    check("store_owner", 64'(OWNER_D), 64'd1);
    D_REQ = 1'b0;
    D_WE  = 1'b0;
    step();
    check("store_done_pulse", 64'(D_DONE), 64'd0);

    // ---------------- contention / starvation ----------------
    D_SIZE  = 2'd3;
    D_ADDR  = 64'h3000;
    IF_ADDR = 64'h4000;
    M_RDATA = 64'hDEAD_BEEF_CAFE_F00D;
    D_REQ   = 1'b1;
    IF_REQ  = 1'b1;
    contend_txn("arb0", 1'b1);
    contend_txn("arb1", 1'b1);
    contend_txn("arb2", 1'b1);
    contend_txn("arb3", 1'b0);
    check("arb3_if_rdata", 64'(IF_RDATA), 64'hCAFE_F00D);
    contend_txn("arb4", 1'b1);
    contend_txn("arb5", 1'b1);
    contend_txn("arb6", 1'b1);
    contend_txn("arb7", 1'b0);
    D_REQ  = 1'b0;
    IF_REQ = 1'b0;
    step();

    // ---------------- ack + err together on a data load ----------------
    D_REQ   = 1'b1;
    D_WE    = 1'b0;
    D_SIZE  = 2'd2;
    D_ADDR  = 64'h5008;
    step();
    check("err_mreq", 64'(M_REQ), 64'd1);
    M_ACK   = 1'b1;
    M_ERR   = 1'b1;
    M_RDATA = 64'h1111_2222_3333_4444;
    step();
    M_ACK = 1'b0;
    M_ERR = 1'b0;
    check("err_done",  64'(D_DONE),  64'd1);
    check("err_fault", 64'(D_FAULT), 64'd1);
    check("err_rdata", D_RDATA,      64'h1111_2222_3333_4444);
    D_REQ = 1'b0;
    step();

    // ---------------- fetch timeout ----------------
    IF_REQ  = 1'b1;
    IF_ADDR = 64'h6000;
    M_RDATA = 64'h9999_8888_7777_6666;
    step();                                   // grant edge 0
    check("tmo_mreq", 64'(M_REQ), 64'd1);
    n = 0;
    while (!IF_DONE && n < 300) begin
      step();
      n++;
    end
    check("tmo_cycles", 64'(n),        64'd255);
    check("tmo_fault",  64'(IF_FAULT), 64'd1);
    check("tmo_rdata",  64'(IF_RDATA), 64'd0);
    check("tmo_mreq_lo", 64'(M_REQ),   64'd0);
    IF_REQ = 1'b0;
    step();
    check("tmo_after", {62'd0, M_REQ, IF_DONE}, 64'd0);

    // ---------------- reset mid-BUSY ----------------
    // Build the starvation count up first so its clearing is visible.
    D_ADDR = 64'h7000;
    D_REQ  = 1'b1;
    IF_REQ = 1'b1;
    contend_txn("pre0", 1'b1);
    contend_txn("pre1", 1'b1);
    step();                                   // third data grant
    check("rstb_mreq", 64'(M_REQ), 64'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("rstb_mreq_lo", 64'(M_REQ), 64'd0);
    check("rstb_done",    {62'd0, D_DONE, IF_DONE}, 64'd0);
    check("rstb_owner",   64'(OWNER_D), 64'd0);
    step();
    RESET = 1'b0;
    // Starvation counter restarted at 0: three data grants before fetch.
    contend_txn("post0", 1'b1);
    contend_txn("post1", 1'b1);
    contend_txn("post2", 1'b1);
    contend_txn("post3", 1'b0);
    D_REQ  = 1'b0;
    IF_REQ = 1'b0;
    step();
    check("end_idle", 64'(M_REQ), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
